// File: rtl/signal_capture_pkg.sv
// Shared types and config checks for the signal capture engine.
// State enum, state width and a parameter sanity function.
package signal_capture_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic bit capture_cfg_ok(
    input int data_w,
    input int depth,
    input int pre
  );
    return (data_w >= 1) && (data_w <= 64) &&
           (depth >= 4) &&
           ((depth & (depth - 1)) == 0) &&
           (pre >= 0) && (pre < depth);
  endfunction

endpackage

// File: rtl/signal_capture_ram.sv
// Simple dual-port capture RAM: one write port, one synchronous read.
// Ports: i_clk, i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata (1-cycle).
module signal_capture_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/signal_capture_buffer.sv
// Logic-analyser capture engine: circular RAM, pre-trigger window,
// level/pattern trigger, sequential readout (rd_en -> rd_data +1 cycle).
// Ports: ILA_Clk, Reset, probe_data, trig_in, trig_mask, trig_value,
//   arm, rd_en -> rd_data, rd_valid, rd_last, triggered, done, state.
// Build option: SIGNAL_CAPTURE_EDGE_TRIG_EN makes both trigger terms
//   fire on rising edges only.
module signal_capture_buffer
  import signal_capture_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic               ILA_Clk,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  probe_data,
  input  logic               trig_in,
  input  logic [DATA_W-1:0]  trig_mask,
  input  logic [DATA_W-1:0]  trig_value,
  input  logic               arm,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               triggered,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  if (!capture_cfg_ok(DATA_W, DEPTH, PRE_TRIG)) begin : g_cfg_err
    $error("signal_capture_buffer: bad DATA_W/DEPTH/PRE_TRIG");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_triggered;
  logic              r_done;

  logic              w_write;
  logic              w_arm_go;
  logic              w_rd_go;
  logic              w_match;
  logic              w_trig;
  logic [DATA_W-1:0] w_ram_q;

  assign w_write = (r_state == ST_PRE_FILL) ||
                   (r_state == ST_ARMED) ||
                   (r_state == ST_POST);

  assign w_arm_go = arm &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // arm wins over a read issued in the same cycle
  assign w_rd_go = rd_en && (r_state == ST_DONE) && !arm;

  assign w_match = (trig_mask != '0) &&
                   ((probe_data & trig_mask) ==
                    (trig_value & trig_mask));

`ifdef SIGNAL_CAPTURE_EDGE_TRIG_EN
  logic r_trig_d;
  logic r_match_d;

  always_ff @(posedge ILA_Clk) begin
    if (Reset || w_arm_go) begin
      r_trig_d  <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_trig_d  <= trig_in;
      r_match_d <= w_match;
    end
  end

  assign w_trig = (trig_in & ~r_trig_d) |
                  (w_match & ~r_match_d);
`else
  assign w_trig = trig_in | w_match;
`endif

  always_ff @(posedge ILA_Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_post_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      r_rd_last  <= w_rd_go &&
                    (r_rd_cnt == ADDR_W'(DEPTH - 1));
      if (w_write)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      // DEPTH reads bring rd_ptr back to the start address
      if (w_rd_go) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= (PRE_TRIG == 0) ? ST_ARMED
                                           : ST_PRE_FILL;
          end
        end
        ST_PRE_FILL: begin
          r_fill_cnt <= r_fill_cnt + 1'b1;
          if (r_fill_cnt == ADDR_W'(PRE_TRIG - 1))
            r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_trig) begin
            // oldest retained sample sits PRE_TRIG before trigger
            r_rd_ptr    <= r_wr_ptr - ADDR_W'(PRE_TRIG);
            r_post_cnt  <= ADDR_W'(POST_N);
            r_triggered <= 1'b1;
            if (POST_N == 0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          r_post_cnt <= r_post_cnt - 1'b1;
          if (r_post_cnt == ADDR_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  signal_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (ILA_Clk),
    .i_we    (w_write && !Reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (probe_data),
    .i_re    (w_rd_go),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  assign rd_data   = r_rd_valid ? w_ram_q : '0;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign triggered = r_triggered;
  assign done      = r_done;
  assign state     = r_state;

endmodule

// File: tb/tb_signal_capture_buffer.sv
// Bench for signal_capture_buffer: DEPTH=16/PRE_TRIG=4 and PRE_TRIG=0.
// Probe bus is a free-running counter; readout checked by a queue.
module tb_signal_capture_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cnt = 16'h0;
  logic        cnt_clr;
  logic        arm, trig_in, rd_en;
  logic        arm0, trig0, rd_en0;
  logic [15:0] mask, value;

  logic [15:0] rd_data, rd_data0;
  logic        rd_valid, rd_valid0;
  logic        rd_last, rd_last0;
  logic        triggered, triggered0;
  logic        done, done0;
  logic [2:0]  state, state0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (cnt_clr) cnt <= 16'h0;
    else         cnt <= cnt + 16'h1;

  signal_capture_buffer #(
    .DATA_W(16), .DEPTH(16), .PRE_TRIG(4)
  ) u_dut (
    .ILA_Clk(clk), .Reset(rst), .probe_data(cnt),
    .trig_in(trig_in), .trig_mask(mask),
    .trig_value(value), .arm(arm), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .triggered(triggered),
    .done(done), .state(state)
  );

  signal_capture_buffer #(
    .DATA_W(16), .DEPTH(16), .PRE_TRIG(0)
  ) u_dut0 (
    .ILA_Clk(clk), .Reset(rst), .probe_data(cnt),
    .trig_in(trig0), .trig_mask(mask),
    .trig_value(value), .arm(arm0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0),
    .rd_last(rd_last0), .triggered(triggered0),
    .done(done0), .state(state0)
  );

  task automatic clear_cnt();
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] v);
    int g;
    g = 0;
    while (cnt !== v && g < 400) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (cnt !== v) begin
      n_errors++;
      $display("FAIL wait_cnt: cnt=%h required %h", cnt, v);
    end
  endtask

  task automatic wait_state(input bit sel, input logic [2:0] st,
                            input string nm);
    int g;
    logic [2:0] s;
    g = 0;
    s = sel ? state0 : state;
    while (s !== st && g < 300) begin
      @(negedge clk);
      g++;
      s = sel ? state0 : state;
    end
    n_checks++;
    if (s !== st) begin
      n_errors++;
      $display("FAIL %s: state=%0d required %0d", nm, s, st);
    end
  endtask

  task automatic set_rd(input bit sel, input logic v);
    if (sel) rd_en0 = v;
    else     rd_en  = v;
  endtask

  task automatic readout(input bit sel, input logic [15:0] start,
                         input string nm);
    logic [16:0] q[$];
    logic [16:0] exp;
    logic [16:0] got;
    logic        v;
    int issued, guard, idx;
    for (int i = 0; i < 16; i++)
      q.push_back({(i == 15), 16'(start + 16'(i))});
    set_rd(sel, 1'b1);
    issued = 1;
    guard  = 0;
    idx    = 0;
    while (q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
      v   = sel ? rd_valid0 : rd_valid;
      got = sel ? {rd_last0, rd_data0} : {rd_last, rd_data};
      if (v) begin
        exp = q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL %s[%0d]: last,data=%h required %h",
                   nm, idx, got, exp);
        end
        idx++;
      end
      if (issued < 16) issued++;
      else set_rd(sel, 1'b0);
    end
    set_rd(sel, 1'b0);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL %s timeout: %0d samples missing required 0",
               nm, q.size());
    end
    @(negedge clk);
    v = sel ? rd_valid0 : rd_valid;
    n_checks++;
    if (v !== 1'b0) begin
      n_errors++;
      $display("FAIL %s idle_valid: rd_valid=%b required 0", nm, v);
    end
  endtask

  task automatic arm_at(input logic [15:0] v);
    wait_cnt(v);
    arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic trig_at(input logic [15:0] v);
    wait_cnt(v);
    trig_in = 1'b1;
    @(negedge clk) trig_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({state, done, triggered, rd_valid, rd_last} !== 7'b0 ||
        rd_data !== 16'h0) begin
      n_errors++;
      $display("FAIL reset: st=%0d d=%b t=%b v=%b l=%b q=%h required 0",
               state, done, triggered, rd_valid, rd_last, rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0 || state !== 3'd0) begin
      n_errors++;
      $display("FAIL idle_read: v=%b st=%0d required 0,0",
               rd_valid, state);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_level_trig();
    clear_cnt();
    arm_at(16'h0010);
    n_checks++;
    if (state !== 3'd1) begin
      n_errors++;
      $display("FAIL lvl_prefill: state=%0d required 1", state);
    end
    wait_cnt(16'h0014);
    n_checks++;
    if (state !== 3'd1) begin
      n_errors++;
      $display("FAIL lvl_prefill_end: state=%0d required 1", state);
    end
    @(negedge clk);
    n_checks++;
    if (state !== 3'd2) begin
      n_errors++;
      $display("FAIL lvl_armed: state=%0d required 2", state);
    end
    trig_at(16'h0040);
    n_checks++;
    if (state !== 3'd3 || triggered !== 1'b1) begin
      n_errors++;
      $display("FAIL lvl_post: st=%0d t=%b required 3,1",
               state, triggered);
    end
    wait_state(1'b0, 3'd4, "lvl_done");
    n_checks++;
    if (cnt !== 16'h004C || done !== 1'b1) begin
      n_errors++;
      $display("FAIL lvl_done_time: cnt=%h done=%b required 004c,1",
               cnt, done);
    end
    readout(1'b0, 16'h003C, "lvl_rd");
    readout(1'b0, 16'h003C, "lvl_rd_again");
  endtask

  task automatic test_held_trig();
    clear_cnt();
    wait_cnt(16'h0010);
    arm = 1'b1;
    trig_in = 1'b1;
    @(negedge clk) arm = 1'b0;
    wait_cnt(16'h0014);
    n_checks++;
    if (state !== 3'd1) begin
      n_errors++;
      $display("FAIL held_prefill: state=%0d required 1", state);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 3'd3) begin
      n_errors++;
      $display("FAIL held_post: state=%0d required 3", state);
    end
    trig_in = 1'b0;
    wait_state(1'b0, 3'd4, "held_done");
    readout(1'b0, 16'h0011, "held_rd");
  endtask

  task automatic test_pattern();
    clear_cnt();
    mask  = 16'h00FF;
    value = 16'h0077;
    arm_at(16'h0010);
    wait_state(1'b0, 3'd4, "pat_done");
    mask  = 16'h0;
    value = 16'h0;
    readout(1'b0, 16'h0073, "pat_rd");
  endtask

  task automatic test_reset_in_post();
    clear_cnt();
    arm_at(16'h0010);
    trig_at(16'h0040);
    wait_cnt(16'h0045);
    n_checks++;
    if (state !== 3'd3) begin
      n_errors++;
      $display("FAIL rip_post: state=%0d required 3", state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({state, done, triggered, rd_valid} !== 6'b0) begin
      n_errors++;
      $display("FAIL rip_reset: st=%0d d=%b t=%b v=%b required 0",
               state, done, triggered, rd_valid);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || state !== 3'd0) begin
        n_errors++;
        $display("FAIL rip_read%0d: v=%b st=%0d required 0,0",
                 i, rd_valid, state);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_arm_over_read();
    clear_cnt();
    arm_at(16'h0010);
    trig_at(16'h0040);
    wait_state(1'b0, 3'd4, "aor_done");
    arm   = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || state !== 3'd1 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL aor: v=%b st=%0d d=%b required 0,1,0",
               rd_valid, state, done);
    end
    trig_at(16'h0060);
    wait_state(1'b0, 3'd4, "aor_done2");
    readout(1'b0, 16'h005C, "aor_rd");
  endtask

  task automatic test_pre0();
    clear_cnt();
    wait_cnt(16'h0010);
    arm0 = 1'b1;
    @(negedge clk) arm0 = 1'b0;
    n_checks++;
    if (state0 !== 3'd2) begin
      n_errors++;
      $display("FAIL p0_armed: state=%0d required 2", state0);
    end
    wait_cnt(16'h0020);
    trig0 = 1'b1;
    @(negedge clk) trig0 = 1'b0;
    wait_state(1'b1, 3'd4, "p0_done");
    readout(1'b1, 16'h0020, "p0_rd");
  endtask

`ifdef SIGNAL_CAPTURE_EDGE_TRIG_EN
  task automatic test_edge_trig();
    trig_in = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_cnt();
    arm_at(16'h0010);
    wait_cnt(16'h0060);
    n_checks++;
    if (state !== 3'd2 || triggered !== 1'b0) begin
      n_errors++;
      $display("FAIL edge_stuck: st=%0d t=%b required 2,0",
               state, triggered);
    end
    trig_in = 1'b0;
    trig_at(16'h0070);
    wait_state(1'b0, 3'd4, "edge_done");
    readout(1'b0, 16'h006C, "edge_rd");
  endtask
`endif

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    arm = 1'b0; trig_in = 1'b0; rd_en = 1'b0;
    arm0 = 1'b0; trig0 = 1'b0; rd_en0 = 1'b0;
    mask = 16'h0; value = 16'h0;
    test_reset();
    test_level_trig();
`ifndef SIGNAL_CAPTURE_EDGE_TRIG_EN
    test_held_trig();
`endif
    test_pattern();
    test_reset_in_post();
    test_arm_over_read();
    test_pre0();
`ifdef SIGNAL_CAPTURE_EDGE_TRIG_EN
    test_edge_trig();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
